// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: bundle between the coprocessor channels, the arbiter and the block memory
//  Parameters: CHANNELS, width (memory word bits), memory_size_log (address bits)
//  Channel side : in_request, out_grant, in_ch_read_en, in_ch_write_en, in_ch_address,
//                 in_ch_data, out_ch_data, out_ch_valid, out_conflict
//  Memory side  : out_mem_read_en, out_mem_write_en, out_mem_address, out_mem_data, in_mem_data
//  slave  = arbiter view, master = channels-plus-memory view
interface mem_arbiter_rr_if #(
  parameter int CHANNELS        = 4,
  parameter int width           = 96,
  parameter int memory_size_log = 8
);
  logic [CHANNELS-1:0]                 in_request;
  logic [CHANNELS-1:0]                 out_grant;
  logic [CHANNELS-1:0]                 in_ch_read_en;
  logic [CHANNELS-1:0]                 in_ch_write_en;
  logic [CHANNELS*memory_size_log-1:0] in_ch_address;
  logic [CHANNELS*width-1:0]           in_ch_data;
  logic [width-1:0]                    out_ch_data;
  logic [CHANNELS-1:0]                 out_ch_valid;
  logic                                out_mem_read_en;
  logic                                out_mem_write_en;
  logic [memory_size_log-1:0]          out_mem_address;
  logic [width-1:0]                    out_mem_data;
  logic [width-1:0]                    in_mem_data;
  logic                                out_conflict;
  modport slave (
    input  in_request, in_ch_read_en, in_ch_write_en, in_ch_address, in_ch_data, in_mem_data,
    output out_grant, out_ch_data, out_ch_valid, out_mem_read_en, out_mem_write_en,
           out_mem_address, out_mem_data, out_conflict
  );
  modport master (
    output in_request, in_ch_read_en, in_ch_write_en, in_ch_address, in_ch_data, in_mem_data,
    input  out_grant, out_ch_data, out_ch_valid, out_mem_read_en, out_mem_write_en,
           out_mem_address, out_mem_data, out_conflict
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one synchronous block memory among CHANNELS coprocessors
//  in_clk   : clock, all state on the rising edge
//  in_reset : synchronous active-high reset
//  bus      : mem_arbiter_rr_if.slave (request/grant, per-channel memory access, memory port, read return)
module mem_arbiter_rr #(
  parameter int CHANNELS        = 4,
  parameter int cell_width      = 32,
  parameter int size            = 3,
  parameter int width           = cell_width * size,
  parameter int memory_size_log = 8,
  parameter int HOLD_MAX        = 16
) (
  input logic             in_clk,
  input logic             in_reset,
  mem_arbiter_rr_if.slave bus
);
  localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] g_idx, g_nxt, ptr, ptr_nxt, sel;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [CHANNELS-1:0] g_onehot, rd_tag, rd_tag_d;
  logic granted, others, preempt, rd_issue, both_en;
  assign granted  = state == GRANT;
  assign g_onehot = CHANNELS'(1) << g_idx;
  assign bus.out_grant = granted ? g_onehot : '0;
  assign others   = |(bus.in_request & ~g_onehot);
  // Counter saturates at HOLD_LAST so a lone long-running owner still yields promptly once someone else asks.
  assign preempt  = HOLD_MAX != 0 && hold_cnt == HOLD_LAST && others;
  assign both_en  = bus.in_ch_read_en[g_idx] & bus.in_ch_write_en[g_idx];
  assign rd_issue = granted & bus.in_ch_read_en[g_idx] & ~bus.in_ch_write_en[g_idx];
  // First requester at or after ptr; scanning downward leaves the lowest offset in sel.
  always_comb begin
    sel = ptr;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (bus.in_request[(int'(ptr) + i) % CHANNELS]) sel = PW'((int'(ptr) + i) % CHANNELS);
  end
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state    <= IDLE;
      g_idx    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      g_idx    <= g_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end
  // ptr moves to g+1 on the way into RELEASE, so RELEASE can already arbitrate
  // from the new position and hand over after a single dead cycle.
  always_comb begin
    state_nxt = state;
    g_nxt     = g_idx;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (granted) begin
      hold_nxt = hold_cnt == HOLD_LAST ? hold_cnt : hold_cnt + 1'b1;
      if (!bus.in_request[g_idx] || preempt) begin
        state_nxt = RELEASE;
        ptr_nxt   = PW'((int'(g_idx) + 1) % CHANNELS);
      end
    end else begin
      hold_nxt  = '0;
      state_nxt = |bus.in_request ? GRANT : IDLE;
      g_nxt     = |bus.in_request ? sel : g_idx;
    end
  end
  // Memory port and read-return pipeline: rd_tag rides with the issued read,
  // rd_tag_d marks the cycle in_mem_data holds that read's word.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      bus.out_mem_read_en  <= 1'b0;
      bus.out_mem_write_en <= 1'b0;
      bus.out_mem_address  <= '0;
      bus.out_mem_data     <= '0;
      bus.out_conflict     <= 1'b0;
      bus.out_ch_valid     <= '0;
      bus.out_ch_data      <= '0;
      rd_tag               <= '0;
      rd_tag_d             <= '0;
    end else begin
      bus.out_mem_read_en  <= rd_issue;
      bus.out_mem_write_en <= granted & bus.in_ch_write_en[g_idx];
      if (granted) begin
        bus.out_mem_address <= bus.in_ch_address[g_idx*memory_size_log +: memory_size_log];
        bus.out_mem_data    <= bus.in_ch_data[g_idx*width +: width];
      end
      if (granted & both_en) bus.out_conflict <= 1'b1;
      rd_tag           <= rd_issue ? g_onehot : '0;
      rd_tag_d         <= rd_tag;
      bus.out_ch_valid <= rd_tag_d;
      if (|rd_tag_d) bus.out_ch_data <= bus.in_mem_data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed table and sequence checks of mem_arbiter_rr with a behavioural memory
module tb_mem_arbiter_rr;
  localparam int C = 4, W = 96, A = 8;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0;
  logic [W-1:0] mem [256];
  mem_arbiter_rr_if #(.CHANNELS(C), .width(W), .memory_size_log(A)) bus ();
  mem_arbiter_rr #(.CHANNELS(C), .cell_width(32), .size(3), .width(W), .memory_size_log(A), .HOLD_MAX(4))
    dut (.in_clk(clk), .in_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.out_mem_write_en) mem[bus.out_mem_address] <= bus.out_mem_data;
    if (bus.out_mem_read_en) bus.in_mem_data <= mem[bus.out_mem_address];
  end
  typedef struct {logic [3:0] req; logic [3:0] exp_grant;} vec_t;
  vec_t tbl[$];
  localparam logic [W-1:0] DAT2 = 96'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAB;
  localparam logic [W-1:0] DAT5 = 96'h1234_5678_9ABC_DEF0_0F0F_F0F0;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_ch(input int k, input logic [A-1:0] addr, input logic [W-1:0] data);
    bus.in_ch_address[k*A +: A] = addr;
    bus.in_ch_data[k*W +: W]    = data;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.in_request = '0;
    bus.in_ch_read_en = '0;
    bus.in_ch_write_en = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.in_request = '1;
    bus.in_ch_read_en = '0;
    bus.in_ch_write_en = '0;
    bus.in_ch_address = '0;
    bus.in_ch_data = '0;
    for (int i = 0; i < 3; i++) tbl.push_back('{4'b1111, 4'b0001});
    tbl.push_back('{4'b1111, 4'b0000});
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < 4; i++) tbl.push_back('{4'b1111, 4'(1 << k)});
      tbl.push_back('{4'b1111, 4'b0000});
    end
    tbl.push_back('{4'b1111, 4'b0001});
    // reset with all requests high, then round-robin rotation
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_grant", bus.out_grant, 0);
    chk("rst_valid", bus.out_ch_valid, 0);
    chk("rst_rd", bus.out_mem_read_en, 0);
    chk("rst_wr", bus.out_mem_write_en, 0);
    chk("rst_addr", bus.out_mem_address, 0);
    chk("rst_data", bus.out_mem_data, 0);
    chk("rst_conflict", bus.out_conflict, 0);
    rst = 1'b0;
    step();
    chk("first_grant", bus.out_grant, 4'b0001);
    foreach (tbl[i]) begin
      bus.in_request = tbl[i].req;
      step();
      chk($sformatf("rr_vec%0d", i), bus.out_grant, tbl[i].exp_grant);
    end
    // ch2 alone: write then read back
    do_reset();
    bus.in_request = 4'b0100;
    step();
    chk("ch2_grant", bus.out_grant, 4'b0100);
    set_ch(2, 8'h10, DAT2);
    bus.in_ch_write_en = 4'b0100;
    step();
    chk("ch2_wr_en", bus.out_mem_write_en, 1);
    chk("ch2_wr_addr", bus.out_mem_address, 8'h10);
    chk("ch2_wr_data", bus.out_mem_data, DAT2);
    bus.in_ch_write_en = '0;
    bus.in_ch_read_en = 4'b0100;
    step();
    chk("ch2_rd_en", bus.out_mem_read_en, 1);
    chk("ch2_rd_wr_off", bus.out_mem_write_en, 0);
    bus.in_ch_read_en = '0;
    step();
    chk("ch2_valid_early", bus.out_ch_valid, 0);
    step();
    chk("ch2_valid", bus.out_ch_valid, 4'b0100);
    chk("ch2_rdata", bus.out_ch_data, DAT2);
    bus.in_ch_write_en = 4'b0001;
    step();
    chk("ch2_valid_pulse", bus.out_ch_valid, 0);
    chk("ch2_data_hold", bus.out_ch_data, DAT2);
    chk("nongrant_wr_ignored", bus.out_mem_write_en, 0);
    bus.in_ch_write_en = '0;
    // read in the last granted cycle returns after the grant drops
    bus.in_ch_read_en = 4'b0100;
    bus.in_request = '0;
    step();
    chk("last_rd_grant", bus.out_grant, 0);
    chk("last_rd_en", bus.out_mem_read_en, 1);
    bus.in_ch_read_en = '0;
    step();
    chk("last_rd_wait", bus.out_ch_valid, 0);
    step();
    chk("last_rd_valid", bus.out_ch_valid, 4'b0100);
    chk("last_rd_data", bus.out_ch_data, DAT2);
    // lone ch1 is never preempted; ch3 arrival forces a handover
    do_reset();
    bus.in_request = 4'b0010;
    step();
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("lone_ch1_c%0d", i), bus.out_grant, 4'b0010);
    end
    bus.in_request = 4'b1010;
    for (int i = 0; i < 4 && bus.out_grant != 0; i++) step();
    chk("preempt_release", bus.out_grant, 0);
    step();
    chk("preempt_ch3", bus.out_grant, 4'b1000);
    // read and write together: write wins, conflict sticks
    do_reset();
    bus.in_request = 4'b0001;
    step();
    set_ch(0, 8'h05, DAT5);
    bus.in_ch_read_en = 4'b0001;
    bus.in_ch_write_en = 4'b0001;
    step();
    chk("cf_wr", bus.out_mem_write_en, 1);
    chk("cf_rd", bus.out_mem_read_en, 0);
    chk("cf_addr", bus.out_mem_address, 8'h05);
    chk("cf_flag", bus.out_conflict, 1);
    bus.in_ch_read_en = '0;
    bus.in_ch_write_en = '0;
    bus.in_request = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("cf_novalid%0d", i), bus.out_ch_valid, 0);
    end
    chk("cf_sticky", bus.out_conflict, 1);
    chk("cf_mem", mem[5], DAT5);
    // reset during an in-flight read, pointer restarts at ch0
    do_reset();
    bus.in_request = 4'b0100;
    step();
    bus.in_request = '0;
    step();
    step();
    bus.in_request = 4'b1100;
    step();
    chk("ptr_after_ch2", bus.out_grant, 4'b1000);
    set_ch(3, 8'h10, '0);
    bus.in_ch_read_en = 4'b1000;
    step();
    chk("inflight_rd", bus.out_mem_read_en, 1);
    bus.in_ch_read_en = '0;
    rst = 1'b1;
    step();
    chk("midrst_grant", bus.out_grant, 0);
    chk("midrst_rd", bus.out_mem_read_en, 0);
    chk("midrst_valid", bus.out_ch_valid, 0);
    rst = 1'b0;
    bus.in_request = 4'b1010;
    step();
    chk("midrst_ptr0", bus.out_grant, 4'b0010);
    chk("midrst_novalid1", bus.out_ch_valid, 0);
    step();
    chk("midrst_novalid2", bus.out_ch_valid, 0);
    chk("midrst_hold", bus.out_grant, 4'b0010);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
